// File: rtl/game_board_ctrl_if.sv
// Command/response bus for the ships board controller.
// The master offers place/shot commands and receives a per-command status;
// the slave (the board controller) accepts commands and returns status.
interface game_board_ctrl_if #(
    parameter int COORD_W = 4,
    parameter int LEN_W   = 3
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_op;
    logic               cmd_player;
    logic [COORD_W-1:0] cmd_x;
    logic [COORD_W-1:0] cmd_y;
    logic [LEN_W-1:0]   cmd_len;
    logic               cmd_vert;
    logic               rsp_valid;
    logic [2:0]         rsp_status;

    modport master (
        output cmd_valid, cmd_op, cmd_player, cmd_x, cmd_y, cmd_len, cmd_vert,
        input  cmd_ready, rsp_valid, rsp_status
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_player, cmd_x, cmd_y, cmd_len, cmd_vert,
        output cmd_ready, rsp_valid, rsp_status
    );

endinterface

// File: rtl/game_board_ctrl.sv
// Two-player board store and rule engine for the ships game.
// Holds a host and a guest board of 2-bit cells, executes placement and shot
// commands one at a time, tracks unhit ship cells and flags game over.
// Boards are stored as full 2**COORD_W square arrays so every coordinate
// indexes directly; cells outside BOARD_SIZE are never written.
module game_board_ctrl #(
    parameter int BOARD_SIZE = 10,
    parameter int COORD_W    = 4,
    parameter int MAX_LEN    = 4,
    parameter int LEN_W      = 3,
    parameter int CNT_W      = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    game_board_ctrl_if.slave   bus,
    input  logic [COORD_W-1:0] rd_h_x,
    input  logic [COORD_W-1:0] rd_h_y,
    output logic [1:0]         rd_h_cell,
    input  logic [COORD_W-1:0] rd_g_x,
    input  logic [COORD_W-1:0] rd_g_y,
    output logic [1:0]         rd_g_cell,
    output logic [CNT_W-1:0]   left_host,
    output logic [CNT_W-1:0]   left_guest,
    output logic               game_over,
    output logic               winner
);

    localparam int                 DIM_C     = 1 << COORD_W;
    localparam logic [COORD_W:0]   LIM_W_C   = (COORD_W+1)'(BOARD_SIZE);
    localparam logic [COORD_W-1:0] LIM_C     = COORD_W'(BOARD_SIZE);
    localparam logic [LEN_W-1:0]   MAX_LEN_C = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   LEN_ONE_C = LEN_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE_C = CNT_W'(1);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    localparam logic [2:0] ST_OK      = 3'b000;
    localparam logic [2:0] ST_BAD_LEN = 3'b001;
    localparam logic [2:0] ST_OOB     = 3'b010;
    localparam logic [2:0] ST_OVERLAP = 3'b011;
    localparam logic [2:0] ST_MISS    = 3'b100;
    localparam logic [2:0] ST_HIT     = 3'b101;
    localparam logic [2:0] ST_REPEAT  = 3'b110;
    localparam logic [2:0] ST_LOCKED  = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_WRITE = 3'd2,
        S_SHOT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Counter add that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [LEN_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + (CNT_W+1)'(b);
        if (sum[CNT_W]) begin
            sat_add = {CNT_W{1'b1}};
        end else begin
            sat_add = sum[CNT_W-1:0];
        end
    endfunction

    // Counter decrement that sticks at zero instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] a);
        if (a == {CNT_W{1'b0}}) begin
            sat_dec = {CNT_W{1'b0}};
        end else begin
            sat_dec = a - CNT_ONE_C;
        end
    endfunction

    state_t             state_r;
    state_t             next_state_s;
    logic [LEN_W-1:0]   idx_r;
    logic [LEN_W-1:0]   next_idx_s;

    logic               op_r;
    logic               player_r;
    logic               vert_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    logic [LEN_W-1:0]   len_r;

    logic [1:0]         host_r  [DIM_C][DIM_C];
    logic [1:0]         guest_r [DIM_C][DIM_C];

    logic [COORD_W:0]   step_s;
    logic [COORD_W:0]   cx_s;
    logic [COORD_W:0]   cy_s;
    logic               inb_s;
    logic [1:0]         cur_cell_s;

    logic               soft_rst_s;
    logic               accept_s;
    logic               wr_en_s;
    logic [1:0]         wr_val_s;
    logic               rsp_load_s;
    logic [2:0]         rsp_code_s;
    logic               cnt_add_s;
    logic               cnt_dec_s;

    logic               rsp_valid_r;
    logic [2:0]         rsp_status_r;
    logic [1:0]         rd_h_cell_r;
    logic [1:0]         rd_g_cell_r;
    logic [CNT_W-1:0]   left_host_r;
    logic [CNT_W-1:0]   left_guest_r;
    logic               game_over_r;
    logic               winner_r;

    assign soft_rst_s    = !rst_n || clear;
    assign bus.cmd_ready = (state_r == S_IDLE) && rst_n && !clear;
    assign accept_s      = bus.cmd_valid && bus.cmd_ready;

    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_status = rsp_status_r;
    assign rd_h_cell      = rd_h_cell_r;
    assign rd_g_cell      = rd_g_cell_r;
    assign left_host      = left_host_r;
    assign left_guest     = left_guest_r;
    assign game_over      = game_over_r;
    assign winner         = winner_r;

    // Current cell address (origin + idx along the direction) and its contents;
    // one extra coordinate bit keeps origin + idx from wrapping into range.
    always_comb begin
        step_s     = (COORD_W+1)'(idx_r);
        cx_s       = {1'b0, x_r};
        cy_s       = {1'b0, y_r};
        cur_cell_s = CELL_EMPTY;
        if (vert_r) begin
            cy_s = {1'b0, y_r} + step_s;
        end else begin
            cx_s = {1'b0, x_r} + step_s;
        end
        inb_s = (cx_s < LIM_W_C) && (cy_s < LIM_W_C);
        if (!inb_s) begin
            cur_cell_s = CELL_EMPTY;
        end else if (player_r) begin
            cur_cell_s = guest_r[cy_s[COORD_W-1:0]][cx_s[COORD_W-1:0]];
        end else begin
            cur_cell_s = host_r[cy_s[COORD_W-1:0]][cx_s[COORD_W-1:0]];
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        next_state_s = state_r;
        next_idx_s   = idx_r;
        wr_en_s      = 1'b0;
        wr_val_s     = CELL_EMPTY;
        rsp_load_s   = 1'b0;
        rsp_code_s   = ST_OK;
        cnt_add_s    = 1'b0;
        cnt_dec_s    = 1'b0;
        case (state_r)
            S_IDLE: begin
                next_idx_s = {LEN_W{1'b0}};
                if (!accept_s) begin
                    next_state_s = S_IDLE;
                end else if (game_over_r) begin
                    next_state_s = S_RESP;
                    rsp_load_s   = 1'b1;
                    rsp_code_s   = ST_LOCKED;
                end else if (!bus.cmd_op) begin
                    next_state_s = S_CHECK;
                end else begin
                    next_state_s = S_SHOT;
                end
            end
            S_CHECK: begin
                if ((idx_r == {LEN_W{1'b0}}) &&
                    ((len_r == {LEN_W{1'b0}}) || (len_r > MAX_LEN_C))) begin
                    next_state_s = S_RESP;
                    rsp_load_s   = 1'b1;
                    rsp_code_s   = ST_BAD_LEN;
                end else if (!inb_s) begin
                    next_state_s = S_RESP;
                    rsp_load_s   = 1'b1;
                    rsp_code_s   = ST_OOB;
                end else if (cur_cell_s != CELL_EMPTY) begin
                    next_state_s = S_RESP;
                    rsp_load_s   = 1'b1;
                    rsp_code_s   = ST_OVERLAP;
                end else if (idx_r == (len_r - LEN_ONE_C)) begin
                    next_state_s = S_WRITE;
                    next_idx_s   = {LEN_W{1'b0}};
                end else begin
                    next_idx_s = idx_r + LEN_ONE_C;
                end
            end
            S_WRITE: begin
                wr_en_s  = 1'b1;
                wr_val_s = CELL_SHIP;
                if (idx_r == (len_r - LEN_ONE_C)) begin
                    next_state_s = S_RESP;
                    rsp_load_s   = 1'b1;
                    rsp_code_s   = ST_OK;
                    cnt_add_s    = 1'b1;
                end else begin
                    next_idx_s = idx_r + LEN_ONE_C;
                end
            end
            S_SHOT: begin
                next_state_s = S_RESP;
                rsp_load_s   = 1'b1;
                if (!inb_s) begin
                    rsp_code_s = ST_OOB;
                end else begin
                    case (cur_cell_s)
                        CELL_EMPTY: begin
                            wr_en_s    = 1'b1;
                            wr_val_s   = CELL_MISS;
                            rsp_code_s = ST_MISS;
                        end
                        CELL_SHIP: begin
                            wr_en_s    = 1'b1;
                            wr_val_s   = CELL_HIT;
                            cnt_dec_s  = 1'b1;
                            rsp_code_s = ST_HIT;
                        end
                        default: begin
                            rsp_code_s = ST_REPEAT;
                        end
                    endcase
                end
            end
            S_RESP: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // FSM state and cell index registers.
    always_ff @(posedge clk) begin
        if (soft_rst_s) begin
            state_r <= S_IDLE;
            idx_r   <= {LEN_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            idx_r   <= next_idx_s;
        end
    end

    // Latch the command fields on accept so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (soft_rst_s) begin
            op_r     <= 1'b0;
            player_r <= 1'b0;
            vert_r   <= 1'b0;
            x_r      <= {COORD_W{1'b0}};
            y_r      <= {COORD_W{1'b0}};
            len_r    <= {LEN_W{1'b0}};
        end else if (accept_s) begin
            op_r     <= bus.cmd_op;
            player_r <= bus.cmd_player;
            vert_r   <= bus.cmd_vert;
            x_r      <= bus.cmd_x;
            y_r      <= bus.cmd_y;
            len_r    <= bus.cmd_len;
        end
    end

    // Board storage: wiped on reset/clear, one cell written per cycle.
    always_ff @(posedge clk) begin
        if (soft_rst_s) begin
            for (int yy = 0; yy < DIM_C; yy++) begin
                for (int xx = 0; xx < DIM_C; xx++) begin
                    host_r[yy][xx]  <= CELL_EMPTY;
                    guest_r[yy][xx] <= CELL_EMPTY;
                end
            end
        end else if (wr_en_s) begin
            if (player_r) begin
                guest_r[cy_s[COORD_W-1:0]][cx_s[COORD_W-1:0]] <= wr_val_s;
            end else begin
                host_r[cy_s[COORD_W-1:0]][cx_s[COORD_W-1:0]] <= wr_val_s;
            end
        end
    end

    // Response pulse and held status code.
    always_ff @(posedge clk) begin
        if (soft_rst_s) begin
            rsp_valid_r  <= 1'b0;
            rsp_status_r <= ST_OK;
        end else begin
            rsp_valid_r <= rsp_load_s;
            if (rsp_load_s) begin
                rsp_status_r <= rsp_code_s;
            end
        end
    end

    // Remaining ship-cell counters and sticky game-over / winner flags.
    always_ff @(posedge clk) begin
        if (soft_rst_s) begin
            left_host_r  <= {CNT_W{1'b0}};
            left_guest_r <= {CNT_W{1'b0}};
            game_over_r  <= 1'b0;
            winner_r     <= 1'b0;
        end else if (cnt_add_s) begin
            if (player_r) begin
                left_guest_r <= sat_add(left_guest_r, len_r);
            end else begin
                left_host_r <= sat_add(left_host_r, len_r);
            end
        end else if (cnt_dec_s) begin
            if (player_r) begin
                left_guest_r <= sat_dec(left_guest_r);
                if (left_guest_r == CNT_ONE_C) begin
                    game_over_r <= 1'b1;
                    winner_r    <= ~player_r;
                end
            end else begin
                left_host_r <= sat_dec(left_host_r);
                if (left_host_r == CNT_ONE_C) begin
                    game_over_r <= 1'b1;
                    winner_r    <= ~player_r;
                end
            end
        end
    end

    // Registered display read ports; out-of-range addresses read as EMPTY.
    always_ff @(posedge clk) begin
        if (soft_rst_s) begin
            rd_h_cell_r <= CELL_EMPTY;
            rd_g_cell_r <= CELL_EMPTY;
        end else begin
            if ((rd_h_x < LIM_C) && (rd_h_y < LIM_C)) begin
                rd_h_cell_r <= host_r[rd_h_y][rd_h_x];
            end else begin
                rd_h_cell_r <= CELL_EMPTY;
            end
            if ((rd_g_x < LIM_C) && (rd_g_y < LIM_C)) begin
                rd_g_cell_r <= guest_r[rd_g_y][rd_g_x];
            end else begin
                rd_g_cell_r <= CELL_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_game_board_ctrl.sv
// Scoreboard bench for game_board_ctrl: the driver computes each command's
// expected status and response cycle from a plain board model and queues it;
// a monitor pops and compares whenever rsp_valid is seen.
module tb_game_board_ctrl;

    localparam int BS = 10;
    localparam int CW = 4;
    localparam int LW = 3;
    localparam int NW = 7;

    localparam int ST_OK = 0, ST_BAD_LEN = 1, ST_OOB = 2, ST_OVERLAP = 3;
    localparam int ST_MISS = 4, ST_HIT = 5, ST_REPEAT = 6, ST_LOCKED = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] rd_h_x, rd_h_y, rd_g_x, rd_g_y;
    logic [1:0]    rd_h_cell, rd_g_cell;
    logic [NW-1:0] left_host, left_guest;
    logic          game_over, winner;

    game_board_ctrl_if #(.COORD_W(CW), .LEN_W(LW)) bus ();

    game_board_ctrl #(
        .BOARD_SIZE(BS), .COORD_W(CW), .MAX_LEN(4), .LEN_W(LW), .CNT_W(NW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus),
        .rd_h_x(rd_h_x), .rd_h_y(rd_h_y), .rd_h_cell(rd_h_cell),
        .rd_g_x(rd_g_x), .rd_g_y(rd_g_y), .rd_g_cell(rd_g_cell),
        .left_host(left_host), .left_guest(left_guest),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: board[player][x][y] holds cell codes 0..3.
    int mb [2][BS][BS];
    int mleft [2];
    bit mover;
    bit mwin;

    typedef struct {
        int st;
        int at;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < 2; p++) begin
            mleft[p] = 0;
            for (int x = 0; x < BS; x++)
                for (int y = 0; y < BS; y++)
                    mb[p][x][y] = 0;
        end
        mover = 1'b0;
        mwin  = 1'b0;
    endfunction

    function automatic int mcell(input int p, input int x, input int y);
        if (x < BS && y < BS) return mb[p][x][y];
        return 0;
    endfunction

    // Apply one command to the model; return status and cycles from accept to rsp.
    function automatic void model_cmd(input bit op, input bit p, input int x, input int y,
                                      input int len, input bit vert,
                                      output int st, output int lat);
        int cx, cy;
        if (mover) begin
            st = ST_LOCKED; lat = 1; return;
        end
        if (!op) begin
            if (len == 0 || len > 4) begin
                st = ST_BAD_LEN; lat = 2; return;
            end
            for (int i = 0; i < len; i++) begin
                cx = vert ? x : x + i;
                cy = vert ? y + i : y;
                if (cx >= BS || cy >= BS) begin
                    st = ST_OOB; lat = i + 2; return;
                end
                if (mb[p][cx][cy] != 0) begin
                    st = ST_OVERLAP; lat = i + 2; return;
                end
            end
            for (int i = 0; i < len; i++) begin
                if (vert) mb[p][x][y+i] = 1;
                else      mb[p][x+i][y] = 1;
            end
            mleft[p] += len;
            st = ST_OK; lat = 2 * len + 1;
        end else begin
            lat = 2;
            if (x >= BS || y >= BS) begin
                st = ST_OOB;
            end else if (mb[p][x][y] == 0) begin
                mb[p][x][y] = 2; st = ST_MISS;
            end else if (mb[p][x][y] == 1) begin
                mb[p][x][y] = 3; st = ST_HIT;
                mleft[p] -= 1;
                if (mleft[p] == 0) begin
                    mover = 1'b1; mwin = ~p;
                end
            end else begin
                st = ST_REPEAT;
            end
        end
    endfunction

    // Monitor: every rsp_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check("rsp_status", int'(bus.rsp_status), mon_e.st);
                check("rsp_cycle", cyc, mon_e.at);
            end
        end
    end

    task automatic scramble();
        bus.cmd_op     = 1'($urandom);
        bus.cmd_player = 1'($urandom);
        bus.cmd_x      = CW'($urandom);
        bus.cmd_y      = CW'($urandom);
        bus.cmd_len    = LW'($urandom);
        bus.cmd_vert   = 1'($urandom);
    endtask

    // Offer one command; on accept, model it and queue the expected response.
    task automatic issue(input bit op, input bit p, input int x, input int y,
                         input int len, input bit vert);
        int st, lat, n;
        @(negedge clk);
        bus.cmd_op = op; bus.cmd_player = p;
        bus.cmd_x = x[CW-1:0]; bus.cmd_y = y[CW-1:0];
        bus.cmd_len = len[LW-1:0]; bus.cmd_vert = vert;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            check("cmd_ready_timeout", 0, 1);
            bus.cmd_valid = 1'b0;
        end else begin
            model_cmd(op, p, x, y, len, vert, st, lat);
            q.push_back('{st, cyc + lat});
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
            scramble();
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            check("rsp_timeout", q.size(), 0);
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_status();
        check("left_host", int'(left_host), mleft[0]);
        check("left_guest", int'(left_guest), mleft[1]);
        check("game_over", int'(game_over), int'(mover));
        if (mover) check("winner", int'(winner), int'(mwin));
    endtask

    // Read every address (including out-of-range ones) on both boards.
    task automatic sweep();
        for (int y = 0; y < 12; y++) begin
            for (int x = 0; x < 12; x++) begin
                @(negedge clk);
                rd_h_x = CW'(x); rd_h_y = CW'(y);
                rd_g_x = CW'(x); rd_g_y = CW'(y);
                @(negedge clk);
                check($sformatf("rd_h_cell(%0d,%0d)", x, y), int'(rd_h_cell), mcell(0, x, y));
                check($sformatf("rd_g_cell(%0d,%0d)", x, y), int'(rd_g_cell), mcell(1, x, y));
            end
        end
    endtask

    task automatic do_clear();
        wait_idle();
        clear = 1'b1;
        #1 check("ready_in_clear", int'(bus.cmd_ready), 0);
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        #1 check("ready_after_clear", int'(bus.cmd_ready), 1);
    endtask

    // Start a len-4 placement, then abort it mid-WRITE with clear or reset.
    task automatic abort_place(input bit use_rst);
        int t0, n;
        wait_idle();
        @(negedge clk);
        bus.cmd_op = 1'b0; bus.cmd_player = 1'b0;
        bus.cmd_x = CW'(0); bus.cmd_y = CW'(0);
        bus.cmd_len = LW'(4); bus.cmd_vert = 1'b0;
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n = 0;
        while (cyc < t0 + 6 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("busy_in_write", int'(bus.cmd_ready), 0);
        if (use_rst) rst_n = 1'b0;
        else         clear = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        clear = 1'b0;
        model_reset();
        #1 check(use_rst ? "ready_after_rst_abort" : "ready_after_clr_abort",
                 int'(bus.cmd_ready), 1);
        repeat (12) @(negedge clk);
        check("rsp_status_cleared", int'(bus.rsp_status), 0);
        check_status();
        sweep();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 1'b0;
        scramble();
        rd_h_x = '0; rd_h_y = '0; rd_g_x = '0; rd_g_y = '0;
        model_reset();

        // Reset state.
        repeat (3) @(negedge clk);
        check("ready_in_reset", int'(bus.cmd_ready), 0);
        check("rsp_valid_rst", int'(bus.rsp_valid), 0);
        check("rsp_status_rst", int'(bus.rsp_status), 0);
        check("rd_h_cell_rst", int'(rd_h_cell), 0);
        check("rd_g_cell_rst", int'(rd_g_cell), 0);
        check("winner_rst", int'(winner), 0);
        check_status();
        rst_n = 1'b1;
        #1 check("ready_after_rst", int'(bus.cmd_ready), 1);

        // Placements: OK, OOB, OVERLAP, BAD_LEN x2.
        issue(1'b0, 1'b0, 2, 5, 3, 1'b0);
        issue(1'b0, 1'b1, 8, 0, 3, 1'b0);
        issue(1'b0, 1'b0, 3, 4, 2, 1'b1);
        issue(1'b0, 1'b0, 0, 0, 0, 1'b0);
        issue(1'b0, 1'b0, 0, 0, 5, 1'b0);
        wait_idle();
        check_status();
        sweep();

        // Shots at the host board: MISS, REPEAT, HIT, OOB.
        issue(1'b1, 1'b0, 0, 0, 0, 1'b0);
        issue(1'b1, 1'b0, 0, 0, 0, 1'b0);
        issue(1'b1, 1'b0, 2, 5, 0, 1'b0);
        issue(1'b1, 1'b0, 12, 1, 0, 1'b0);
        wait_idle();
        check_status();

        // Sink the host ship, then everything is LOCKED.
        issue(1'b1, 1'b0, 3, 5, 0, 1'b0);
        issue(1'b1, 1'b0, 4, 5, 0, 1'b0);
        wait_idle();
        check_status();
        issue(1'b0, 1'b1, 1, 1, 2, 1'b0);
        issue(1'b1, 1'b1, 1, 1, 0, 1'b0);
        wait_idle();
        check_status();
        sweep();

        // Clear and aborted placements.
        do_clear();
        check_status();
        abort_place(1'b0);
        abort_place(1'b1);

        // Randomized play against the model.
        for (int k = 0; k < 400; k++) begin
            if (mover && $urandom_range(0, 3) == 0) do_clear();
            if ($urandom_range(0, 2) == 0)
                issue(1'b1, 1'($urandom), $urandom_range(0, 11), $urandom_range(0, 11),
                      0, 1'b0);
            else
                issue(1'b0, 1'($urandom), $urandom_range(0, 11), $urandom_range(0, 11),
                      $urandom_range(0, 5), 1'($urandom));
            if (k % 50 == 49) begin
                wait_idle();
                check_status();
            end
        end
        wait_idle();
        check_status();
        sweep();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
